// File: rtl/rv_ctl.sv
// Multicycle RV32I control FSM (fetch/decode/exec/mem/writeback) for the rv_dp datapath.
// Optional: define RV_CTL_ILLEGAL_HALT_EN to halt on unsupported opcodes instead of skipping them.
module rv_ctl #(
  parameter int DPWIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DPWIDTH-1:0] instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcsourse,
  output logic               pcwrite,
  output logic               pccen,
  output logic               irwrite,
  output logic [1:0]         wbsel,
  output logic               regwen,
  output logic [1:0]         immsel,
  output logic [1:0]         asel,
  output logic [1:0]         bsel,
  output logic [3:0]         alusel,
  output logic               mdrwrite,
  output logic               dmem_we,
  output logic               illegal
);

  localparam logic       PC_PLUS4   = 1'b0;
  localparam logic       PC_ALU     = 1'b1;
  localparam logic [1:0] WB_MDR     = 2'd0;
  localparam logic [1:0] WB_ALUOUT  = 2'd1;
  localparam logic [1:0] WB_PC      = 2'd2;
  localparam logic [1:0] IMM_J      = 2'd0;
  localparam logic [1:0] IMM_B      = 2'd1;
  localparam logic [1:0] IMM_S      = 2'd2;
  localparam logic [1:0] IMM_L      = 2'd3;
  localparam logic [1:0] ALUA_PCC   = 2'd0;
  localparam logic [1:0] ALUA_REG   = 2'd1;
  localparam logic [1:0] ALUB_REG   = 2'd0;
  localparam logic [1:0] ALUB_IMM   = 2'd1;
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, WBM, JUMP, ILLEGAL, HALT
  } state_t;

  state_t state, next_state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign bit30       = instr[30];
  assign unused_bits = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic r_type, input logic b30);
    case (f3)
      3'b000:  alu_op = (r_type && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

`ifdef RV_CTL_ILLEGAL_HALT_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst)                  illegal_q <= 1'b0;
    else if (state == ILLEGAL) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    next_state = state;
    pcsourse   = PC_PLUS4;
    pcwrite    = 1'b0;
    pccen      = 1'b0;
    irwrite    = 1'b0;
    wbsel      = WB_ALUOUT;
    regwen     = 1'b0;
    immsel     = IMM_L;
    asel       = ALUA_REG;
    bsel       = ALUB_IMM;
    alusel     = ALU_ADD;
    mdrwrite   = 1'b0;
    dmem_we    = 1'b0;

    case (state)
      FETCH: begin
        if (mem_ready) begin
          irwrite    = 1'b1;
          pccen      = 1'b1;
          pcwrite    = 1'b1;
          next_state = DECODE;
        end
      end

      // aluout = pcc + imm is the branch/jump target used later.
      DECODE: begin
        asel   = ALUA_PCC;
        immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: next_state = EXEC;
          OP_JAL:                                   next_state = JUMP;
          default:                                  next_state = ILLEGAL;
        endcase
      end

      EXEC: begin
        case (opcode)
          OP_R: begin
            bsel       = ALUB_REG;
            alusel     = alu_op(funct3, 1'b1, bit30);
            next_state = WB;
          end
          OP_I: begin
            alusel     = alu_op(funct3, 1'b0, bit30);
            next_state = WB;
          end
          OP_LOAD: next_state = MEM_RD;
          OP_STORE: begin
            immsel     = IMM_S;
            next_state = MEM_WR;
          end
          default: begin
            bsel       = ALUB_REG;
            next_state = FETCH;
            case (funct3)
              3'b000: begin alusel = ALU_SUB;  pcwrite = zero;  end
              3'b001: begin alusel = ALU_SUB;  pcwrite = !zero; end
              3'b100: begin alusel = ALU_SLT;  pcwrite = !zero; end
              3'b101: begin alusel = ALU_SLT;  pcwrite = zero;  end
              3'b110: begin alusel = ALU_SLTU; pcwrite = !zero; end
              3'b111: begin alusel = ALU_SLTU; pcwrite = zero;  end
              default: pcwrite = 1'b0;
            endcase
            if (pcwrite) pcsourse = PC_ALU;
          end
        endcase
      end

      MEM_RD: begin
        mdrwrite = mem_ready;
        if (mem_ready) next_state = WBM;
      end

      MEM_WR: begin
        immsel  = IMM_S;
        dmem_we = 1'b1;
        if (mem_ready) next_state = FETCH;
      end

      WB: begin
        regwen     = 1'b1;
        wbsel      = WB_ALUOUT;
        next_state = FETCH;
      end

      WBM: begin
        regwen     = 1'b1;
        wbsel      = WB_MDR;
        next_state = FETCH;
      end

      JUMP: begin
        regwen     = 1'b1;
        wbsel      = WB_PC;
        pcwrite    = 1'b1;
        pcsourse   = PC_ALU;
        next_state = FETCH;
      end

`ifdef RV_CTL_ILLEGAL_HALT_EN
      ILLEGAL: next_state = HALT;
      HALT:    next_state = HALT;
`else
      ILLEGAL: next_state = FETCH;
      HALT:    next_state = FETCH;
`endif

      default: next_state = FETCH;
    endcase

    // A reset cycle must never leak a write into the datapath.
    if (rst) begin
      pcwrite  = 1'b0;
      pccen    = 1'b0;
      irwrite  = 1'b0;
      regwen   = 1'b0;
      mdrwrite = 1'b0;
      dmem_we  = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_ctl.sv
// Directed self-checking bench for rv_ctl; expected values are hand-computed per instruction step.
module tb_rv_ctl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, dmem_we, illegal;
  logic [1:0]  wbsel, immsel, asel, bsel;
  logic [3:0]  alusel;

  int checkCount = 0;
  int passCount  = 0;

  rv_ctl #(.DPWIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
    .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
    .alusel(alusel), .mdrwrite(mdrwrite), .dmem_we(dmem_we), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encodings the controller is expected to drive.
  localparam logic [31:0] PC_PLUS4 = 0, PC_ALU = 1;
  localparam logic [31:0] WB_MDR = 0, WB_ALUOUT = 1, WB_PC = 2;
  localparam logic [31:0] IMM_J = 0, IMM_B = 1, IMM_S = 2, IMM_L = 3;
  localparam logic [31:0] ALUA_PCC = 0, ALUA_REG = 1, ALUB_REG = 0, ALUB_IMM = 1;
  localparam logic [31:0] ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 3, ALU_SLTU = 4, ALU_SRA = 7;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic z, input logic mr);
    rst       = r;
    instr     = ins;
    zero      = z;
    mem_ready = mr;
    #1;
  endtask

  // Runs a FETCH (mem_ready=1) then a DECODE for ins, checking the fetch strobes and decode immsel.
  task automatic fetchDecode(input string name, input logic [31:0] ins, input logic [31:0] imm_exp);
    applyStimulus(1'b0, ins, 1'b0, 1'b1);
    checkOutput({name, " fetch irwrite"}, {31'b0, irwrite}, 1);
    tick();
    applyStimulus(1'b0, ins, 1'b0, 1'b1);
    checkOutput({name, " decode asel"}, {30'b0, asel}, ALUA_PCC);
    checkOutput({name, " decode immsel"}, {30'b0, immsel}, imm_exp);
    tick();
  endtask

  initial begin
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
    checkOutput("reset pcwrite", {31'b0, pcwrite}, 0);
    checkOutput("reset irwrite", {31'b0, irwrite}, 0);
    checkOutput("reset illegal", {31'b0, illegal}, 0);

    // First cycle after reset: fetch strobes.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("fetch0 pcwrite", {31'b0, pcwrite}, 1);
    checkOutput("fetch0 pccen", {31'b0, pccen}, 1);
    checkOutput("fetch0 pcsourse", {31'b0, pcsourse}, PC_PLUS4);

    // Fetch wait-state holds everything off.
    applyStimulus(1'b0, 32'h002081B3, 1'b0, 1'b0);
    checkOutput("fetch wait irwrite", {31'b0, irwrite}, 0);
    tick();

    // ADD x3,x1,x2
    fetchDecode("add", 32'h002081B3, IMM_B);
    applyStimulus(1'b0, 32'h002081B3, 1'b0, 1'b1);
    checkOutput("add exec alusel", {28'b0, alusel}, ALU_ADD);
    checkOutput("add exec bsel", {30'b0, bsel}, ALUB_REG);
    checkOutput("add exec asel", {30'b0, asel}, ALUA_REG);
    tick();
    checkOutput("add wb regwen", {31'b0, regwen}, 1);
    checkOutput("add wb wbsel", {30'b0, wbsel}, WB_ALUOUT);
    tick();
    checkOutput("add back fetch", {31'b0, irwrite}, 1);

    // SUB x2,x1,x2
    fetchDecode("sub", 32'h40208133, IMM_B);
    checkOutput("sub exec alusel", {28'b0, alusel}, ALU_SUB);
    tick(); tick();

    // SRAI x1,x1,3
    fetchDecode("srai", 32'h4030D093, IMM_B);
    checkOutput("srai exec alusel", {28'b0, alusel}, ALU_SRA);
    checkOutput("srai exec bsel", {30'b0, bsel}, ALUB_IMM);
    checkOutput("srai exec immsel", {30'b0, immsel}, IMM_L);
    tick(); tick();

    // LW x5,8(x1) with two wait states in MEM_RD
    fetchDecode("lw", 32'h0080A283, IMM_B);
    checkOutput("lw exec immsel", {30'b0, immsel}, IMM_L);
    tick();
    applyStimulus(1'b0, 32'h0080A283, 1'b0, 1'b0);
    checkOutput("lw memrd1 mdrwrite", {31'b0, mdrwrite}, 0);
    tick();
    applyStimulus(1'b0, 32'h0080A283, 1'b0, 1'b0);
    checkOutput("lw memrd2 mdrwrite", {31'b0, mdrwrite}, 0);
    tick();
    applyStimulus(1'b0, 32'h0080A283, 1'b0, 1'b1);
    checkOutput("lw memrd3 mdrwrite", {31'b0, mdrwrite}, 1);
    checkOutput("lw memrd3 alusel", {28'b0, alusel}, ALU_ADD);
    tick();
    checkOutput("lw wbm regwen", {31'b0, regwen}, 1);
    checkOutput("lw wbm wbsel", {30'b0, wbsel}, WB_MDR);
    tick();

    // SW x2,4(x1) with one wait state
    fetchDecode("sw", 32'h0020A223, IMM_B);
    checkOutput("sw exec immsel", {30'b0, immsel}, IMM_S);
    tick();
    applyStimulus(1'b0, 32'h0020A223, 1'b0, 1'b0);
    checkOutput("sw memwr wait dmem_we", {31'b0, dmem_we}, 1);
    tick();
    applyStimulus(1'b0, 32'h0020A223, 1'b0, 1'b1);
    checkOutput("sw memwr dmem_we", {31'b0, dmem_we}, 1);
    tick();
    checkOutput("sw back fetch", {31'b0, irwrite}, 1);

    // BEQ zero=1 taken
    fetchDecode("beq", 32'h00208463, IMM_B);
    applyStimulus(1'b0, 32'h00208463, 1'b1, 1'b1);
    checkOutput("beq pcwrite", {31'b0, pcwrite}, 1);
    checkOutput("beq pcsourse", {31'b0, pcsourse}, PC_ALU);
    checkOutput("beq alusel", {28'b0, alusel}, ALU_SUB);
    tick();

    // BNE zero=1 not taken
    fetchDecode("bne", 32'h00209463, IMM_B);
    applyStimulus(1'b0, 32'h00209463, 1'b1, 1'b1);
    checkOutput("bne pcwrite", {31'b0, pcwrite}, 0);
    tick();

    // BLT zero=0 taken
    fetchDecode("blt", 32'h0020C463, IMM_B);
    applyStimulus(1'b0, 32'h0020C463, 1'b0, 1'b1);
    checkOutput("blt pcwrite", {31'b0, pcwrite}, 1);
    checkOutput("blt alusel", {28'b0, alusel}, ALU_SLT);
    tick();

    // BGEU zero=0 not taken
    fetchDecode("bgeu", 32'h0020F463, IMM_B);
    applyStimulus(1'b0, 32'h0020F463, 1'b0, 1'b1);
    checkOutput("bgeu pcwrite", {31'b0, pcwrite}, 0);
    checkOutput("bgeu alusel", {28'b0, alusel}, ALU_SLTU);
    tick();

    // JAL x1,+16
    fetchDecode("jal", 32'h010000EF, IMM_J);
    checkOutput("jal regwen", {31'b0, regwen}, 1);
    checkOutput("jal wbsel", {30'b0, wbsel}, WB_PC);
    checkOutput("jal pcwrite", {31'b0, pcwrite}, 1);
    checkOutput("jal pcsourse", {31'b0, pcsourse}, PC_ALU);
    tick();
    checkOutput("jal back fetch", {31'b0, irwrite}, 1);

    // Reset in the WB cycle of an ADD suppresses the register write.
    fetchDecode("rstmid", 32'h002081B3, IMM_B);
    tick();
    applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b1);
    checkOutput("rstmid regwen", {31'b0, regwen}, 0);
    tick();
    applyStimulus(1'b0, 32'h002081B3, 1'b0, 1'b1);
    checkOutput("rstmid fetch irwrite", {31'b0, irwrite}, 1);

    // LUI is unsupported
    fetchDecode("lui", 32'h000012B7, IMM_B);
    checkOutput("lui illegal-state irwrite", {31'b0, irwrite}, 0);
    tick();
`ifdef RV_CTL_ILLEGAL_HALT_EN
    checkOutput("lui halt illegal", {31'b0, illegal}, 1);
    checkOutput("lui halt irwrite", {31'b0, irwrite}, 0);
    tick();
    checkOutput("lui halt stays", {31'b0, irwrite}, 0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("lui after rst illegal", {31'b0, illegal}, 0);
    checkOutput("lui after rst irwrite", {31'b0, irwrite}, 1);
`else
    checkOutput("lui nop illegal", {31'b0, illegal}, 0);
    checkOutput("lui nop resume irwrite", {31'b0, irwrite}, 1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
